// File: rtl/onehot_serial_encoder_if.sv
// Handshake bundle for onehot_serial_encoder.
// The vector-in side and the index-out stream share one interface.
// The slave modport is the encoder's view. The master modport is the
// view of the logic that drives vectors and consumes indices.
interface onehot_serial_encoder_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    // Vector-in handshake
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_vec;

    // Index-out stream
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_idx;
    logic         out_last;

    // Status
    logic         zero_vec;
    logic         busy;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output zero_vec,
        output busy
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  zero_vec,
        input  busy
    );
endinterface

// File: rtl/onehot_serial_encoder.sv
// onehot_serial_encoder: accepts a 2**N-bit request vector and streams the
// binary index of every set bit, one index per out handshake. out_last
// marks the final index of each vector.
//
// Optional macro ONEHOT_ENC_MSB_FIRST_EN selects the scan order:
//   undefined - lowest set bit first (ascending order)
//   defined   - highest set bit first (descending order)
//
// Every stream output is decoded from r_state and r_pending only, so there
// is no combinational path from the in_* inputs to the out_* outputs.
module onehot_serial_encoder #(
    parameter int N = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    onehot_serial_encoder_if.slave  bus
);
    localparam int W = 1 << N;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_pending;
    logic [W-1:0] w_pending_next;
    logic         r_zero_vec;
    logic         w_zero_vec_next;

    // w_chain carries the running OR of pending bits that have already
    // been passed in scan order. A bit is selected when it is set and no
    // earlier bit in scan order is set.
    logic [W:0]   w_chain;
    logic [W-1:0] w_sel;
    logic         w_any;
    logic         w_single;
    logic [N-1:0] w_idx;
    logic [W-1:0] w_idx_terms [N];

    generate
        genvar gi;
        genvar gb;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        // Descending scan: w_chain[gi] is the OR of r_pending[W-1:gi].
        assign w_chain[W] = 1'b0;
        for (gi = 0; gi < W; gi = gi + 1) begin : g_scan
            assign w_chain[gi] = w_chain[gi+1] | r_pending[gi];
            assign w_sel[gi]   = r_pending[gi] & ~w_chain[gi+1];
        end
        assign w_any = w_chain[0];
`else
        // Ascending scan: w_chain[gi] is the OR of r_pending[gi-1:0].
        assign w_chain[0] = 1'b0;
        for (gi = 0; gi < W; gi = gi + 1) begin : g_scan
            assign w_chain[gi+1] = w_chain[gi] | r_pending[gi];
            assign w_sel[gi]     = r_pending[gi] & ~w_chain[gi];
        end
        assign w_any = w_chain[W];
`endif

        // Binary encoding of the one-hot select. Output bit gb is the OR of
        // the select lines whose index has bit gb set. An empty pending
        // register gives an all-zero select, so w_idx is forced to 0.
        for (gb = 0; gb < N; gb = gb + 1) begin : g_enc_bit
            for (gi = 0; gi < W; gi = gi + 1) begin : g_enc_term
                if (((gi >> gb) % 2) == 1) begin : g_on
                    assign w_idx_terms[gb][gi] = w_sel[gi];
                end else begin : g_off
                    assign w_idx_terms[gb][gi] = 1'b0;
                end
            end
            assign w_idx[gb] = |w_idx_terms[gb];
        end
    endgenerate

    // Exactly one bit is set: the register is non-empty, and clearing its
    // lowest set bit leaves it empty.
    assign w_single = w_any
                    & ~(|(r_pending & (r_pending - {{(W-1){1'b0}}, 1'b1})));

    // Registered outputs and state-decoded outputs
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.busy      = (r_state == ST_EMIT);
    assign bus.out_idx   = w_idx;
    assign bus.out_last  = w_single;
    assign bus.zero_vec  = r_zero_vec;

    // State, pending vector and the zero_vec pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_zero_vec <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_zero_vec <= w_zero_vec_next;
        end
    end

    // Next-state logic: accept a vector in IDLE; retire one index per
    // out handshake in EMIT.
    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = r_pending;
        w_zero_vec_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec == '0) begin
                        // Nothing to stream. Flag it and keep accepting.
                        w_zero_vec_next = 1'b1;
                    end else begin
                        w_pending_next = bus.in_vec;
                        w_state_next   = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    w_pending_next = r_pending & ~w_sel;
                    if (w_single) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Self-checking bench for onehot_serial_encoder.
// The reference model turns each accepted vector into a queue of expected
// indices, in scan order. Each out handshake pops the head of the queue.
module tb_onehot_serial_encoder;
    localparam int N      = 3;
    localparam int W      = 1 << N;
    localparam int BUDGET = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    onehot_serial_encoder_if #(.N(N)) bus ();

    onehot_serial_encoder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the positions of the set bits, listed in scan order.
    function automatic void build_expected(input logic [W-1:0] vec, output int q[$]);
        q = {};
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        for (int i = W - 1; i >= 0; i--) if (vec[i]) q.push_back(i);
`else
        for (int i = 0; i < W; i++) if (vec[i]) q.push_back(i);
`endif
    endfunction

    // mode 0: out_ready always high
    // mode 1: out_ready random
    // mode 2: out_ready low for the first 3 cycles, then high
    // The task is called and returns at a negedge while the DUT is in IDLE.
    task automatic send_vec(input logic [W-1:0] vec, input int mode);
        int   q[$];
        int   cyc;
        int   emitted;
        logic rdy;
        check("pre_in_ready", bus.in_ready, 1);
        check("pre_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_vec   = W'($urandom);
        build_expected(vec, q);
        if (q.size() == 0) begin
            check("zero_pulse", bus.zero_vec, 1);
            check("zero_out_valid", bus.out_valid, 0);
            check("zero_in_ready", bus.in_ready, 1);
            @(negedge clk);
            check("zero_pulse_end", bus.zero_vec, 0);
            check("zero_out_valid2", bus.out_valid, 0);
            $display("vec %02h mode %0d: zero vector", vec, mode);
            return;
        end
        cyc     = 0;
        emitted = 0;
        while (q.size() > 0 && cyc < BUDGET) begin
            check("out_valid", bus.out_valid, 1);
            check("busy", bus.busy, 1);
            check("in_ready_emit", bus.in_ready, 0);
            check("zero_vec_emit", bus.zero_vec, 0);
            check("out_idx", 32'(bus.out_idx), 32'(q[0]));
            check("out_last", bus.out_last, (q.size() == 1) ? 1 : 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom % 2);
                default: rdy = (cyc >= 3);
            endcase
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                void'(q.pop_front());
                emitted++;
            end
            // Drive junk into the ignored vector input while emitting.
            bus.in_valid = (q.size() > 0) ? 1'($urandom % 2) : 1'b0;
            bus.in_vec   = W'($urandom);
            cyc++;
        end
        check("emit_budget", (cyc < BUDGET) ? 1 : 0, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", bus.busy, 0);
        check("post_out_last", bus.out_last, 0);
        $display("vec %02h mode %0d: %0d indices in %0d cycles", vec, mode, emitted, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        // Reset is held low while the vector input is valid.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vec    = 8'hA5;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx", 32'(bus.out_idx), 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_zero_vec", bus.zero_vec, 0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", bus.out_valid, 0);
        end
        $display("reset: checked");

        // Directed vectors
        send_vec(8'b1010_0100, 0);
        send_vec(8'b1010_0100, 2);
        send_vec(8'h00, 0);
        send_vec(8'h80, 0);
        send_vec(8'hFF, 0);
        send_vec(8'h01, 1);

        // Reset asserted mid-stream, after the first index (4) is accepted
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hF0;
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        check("mid_first_idx", 32'(bus.out_idx), 7);
`else
        check("mid_first_idx", 32'(bus.out_idx), 4);
`endif
        check("mid_first_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_idx", 32'(bus.out_idx), 0);
        check("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rst_no_emit", bus.out_valid, 0);
            check("mid_rst_ready", bus.in_ready, 1);
        end
        bus.out_ready = 1'b0;
        $display("reset mid-emit: checked");

        // Randomized vectors with random flow control
        for (int t = 0; t < 40; t++) begin
            v = (($urandom % 8) == 0) ? '0 : W'($urandom);
            send_vec(v, int'($urandom % 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/onehot_serial_encoder.md
Name: onehot_serial_encoder

Overview:
- Reverse of the n-bit one-hot decoder: takes a 2**N-bit request vector and streams the binary index of every set bit, one index per handshake.
- Vector-in side uses a valid/ready handshake; index-out side uses a valid/ready stream with a last marker.
- Used after decoder-driven request/flag vectors to turn them back into index sequences for downstream sequential logic.

Parameters:
- N, 3, index width; the input vector width is 2**N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is presented
- in_ready  output  1  block can accept a vector; high only in IDLE
- in_vec  input  2**N  request vector, any number of bits set
- out_valid  output  1  out_idx holds a valid index
- out_ready  input  1  downstream accepts out_idx
- out_idx  output  N  binary index of the current set bit
- out_last  output  1  out_idx is the final index of this vector
- zero_vec  output  1  one-cycle pulse: an all-zero vector was accepted
- busy  output  1  high in EMIT

Behaviour:
- Two states: IDLE and EMIT. Internal register `pending` is 2**N bits wide.
- Reset (rst_n low, asynchronous):
  - state=IDLE, pending=0, zero_vec=0.
  - Outputs: out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1.
- Output derivation:
  - in_ready = (state==IDLE).
  - busy = out_valid = (state==EMIT).
  - out_idx = index of the lowest set bit of pending. Forced to 0 when pending==0.
  - out_last = (exactly one bit set in pending).
  - All of these are decoded from registers only; there is no combinational path from in_* to out_*.
- IDLE, when in_valid && in_ready:
  - in_vec==0: zero_vec=1 for the next cycle only; stay in IDLE.
  - in_vec!=0: pending<=in_vec; go to EMIT. out_valid rises on the cycle after acceptance, so first-index latency is 1 cycle.
- EMIT, when out_valid && out_ready:
  - Clear bit out_idx in pending.
  - If out_last, go to IDLE. out_valid drops and in_ready rises on the next cycle.
  - Otherwise stay in EMIT; the next index appears on the next cycle.
- Throughput: with out_ready held high, K set bits produce K indices on K consecutive cycles, followed by 1 IDLE cycle before the next vector can be accepted.
- Backpressure: while out_ready=0, out_idx, out_last and out_valid hold stable. out_valid never drops without a completed handshake.
- In EMIT, in_valid is ignored (in_ready=0) and in_vec is not sampled.
- Full vector (all 2**N bits set): emits indices 0..2**N-1 in order; out_last is set only on index 2**N-1.
- Reset asserted mid-EMIT: pending is discarded immediately, outputs return to their reset values, and nothing further is emitted.
- zero_vec is never asserted in EMIT.

Optional Feature:
- Macro ONEHOT_ENC_MSB_FIRST_EN.
- Defined: out_idx is the highest set bit of pending, so scan order is descending. Each handshake clears that bit. out_last rule is unchanged.
- Not defined: ascending order (lowest set bit first), as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_idx=0, in_ready=1, busy=0; after release, no emission until a new vector is accepted.
- Ascending stream: N=3, in_vec=8'b1010_0100, out_ready=1 -> out_idx 2,5,7 on 3 consecutive cycles starting 1 cycle after acceptance; out_last=1 only with 7; in_ready=1 on the following cycle.
- Backpressure: same vector, out_ready=0 for 3 cycles while out_idx=2 -> out_idx=2, out_valid=1, out_last=0 held; after out_ready=1, 5 then 7 follow.
- Edge vectors: in_vec=8'h00 -> zero_vec pulse 1 cycle, out_valid stays 0. in_vec=8'h80 -> single out_idx=7 with out_last=1. in_vec=8'hFF -> 0..7, out_last only on 7.
- Reset mid-EMIT: in_vec=8'hF0, assert rst_n=0 after index 4 is accepted -> out_valid=0 immediately; after release, in_ready=1 and indices 5..7 are never emitted.
- With ONEHOT_ENC_MSB_FIRST_EN defined: in_vec=8'b1010_0100 -> out_idx 7,5,2, out_last on 2.
